// File: rtl/count_start_sequencer_if.sv
// Host-side command/response channel of the count/start sequencer.
//   cmd_valid/cmd_ready/cmd_target : one target-count command per handshake
//   rsp_valid/rsp_ready            : one status response per command
//   rsp_timeout/rsp_count          : run outcome and count sampled at run end
// master = host side, slave = sequencer side.
interface count_start_sequencer_if #(
  parameter int unsigned CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_target;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_timeout;
  logic [CNT_W-1:0] rsp_count;

  modport master (
    output cmd_valid, cmd_target, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_timeout, rsp_count
  );

  modport slave (
    input  cmd_valid, cmd_target, rsp_ready,
    output cmd_ready, rsp_valid, rsp_timeout, rsp_count
  );
endinterface

// File: rtl/count_start_sequencer.sv
// Upstream controller for the start/count counter stage. Takes a target-count
// command, pulses start for one cycle, watches the counter until it reaches
// the target or the timeout expires, then returns one status response.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   host_if        : command/response channel (slave side)
//   start_o        : one-cycle start pulse to the counter stage
//   count_i        : running count from the counter stage
//   busy_o         : high whenever the sequencer is not idle
module count_start_sequencer #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned GAP_CYC     = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  count_start_sequencer_if.slave  host_if,
  output logic                    start_o,
  input  logic [CNT_W-1:0]        count_i,
  output logic                    busy_o
);

  localparam int unsigned TMR_W    = $clog2(TIMEOUT_CYC);
  localparam int unsigned GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP,
    S_GAP
  } state_e;

  state_e             state_q;
  logic               start_q;
  logic               rsp_valid_q;
  logic               rsp_timeout_q;
  logic [CNT_W-1:0]   rsp_count_q;
  logic [TMR_W-1:0]   timer_q;
  logic [CNT_W-1:0]   target_q;
  logic [GAP_W-1:0]   gap_q;

  logic hit_c;
  logic expired_c;

  // Compare is masked on the first WAIT cycle: the counter is still reacting to start.
  assign hit_c     = (timer_q != '0) && (count_i >= target_q);
  assign expired_c = (timer_q == TMR_W'(TIMEOUT_CYC - 1));

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      start_q       <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_count_q   <= '0;
      timer_q       <= '0;
      target_q      <= '0;
      gap_q         <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (host_if.cmd_valid) begin
            target_q <= host_if.cmd_target;
            start_q  <= 1'b1;
            state_q  <= S_START;
          end
        end
        S_START: begin
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          timer_q <= timer_q + 1'b1;
          if (hit_c || expired_c) begin
            // A hit on the final timer cycle still reports success.
            rsp_timeout_q <= !hit_c;
            rsp_count_q   <= count_i;
            rsp_valid_q   <= 1'b1;
            state_q       <= S_RESP;
          end
        end
        S_RESP: begin
          if (host_if.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            gap_q       <= '0;
            state_q     <= (GAP_CYC == 0) ? S_IDLE : S_GAP;
          end
        end
        S_GAP: begin
          if (gap_q == GAP_W'(GAP_LAST)) begin
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // cmd_ready must drop as soon as reset is asserted, not one edge later.
  assign host_if.cmd_ready   = (state_q == S_IDLE) && !reset_i;
  assign host_if.rsp_valid   = rsp_valid_q;
  assign host_if.rsp_timeout = rsp_timeout_q;
  assign host_if.rsp_count   = rsp_count_q;
  assign start_o             = start_q;
  assign busy_o              = (state_q != S_IDLE);

endmodule

// File: tb/tb_count_start_sequencer.sv
// Directed bench for count_start_sequencer with a counter-stage model and a
// response scoreboard.
module tb_count_start_sequencer;

  localparam int unsigned CNT_W       = 8;
  localparam int unsigned TIMEOUT_CYC = 16;
  localparam int unsigned GAP_CYC     = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] count;
  logic             busy;

  always #5 clk = ~clk;

  count_start_sequencer_if #(.CNT_W(CNT_W)) host_if ();

  count_start_sequencer #(
    .CNT_W      (CNT_W),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .GAP_CYC    (GAP_CYC)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .host_if(host_if),
    .start_o(start),
    .count_i(count),
    .busy_o (busy)
  );

  // Counter stage model: clears on start, then counts up one per cycle.
  logic [CNT_W-1:0] cnt_q = '0;
  logic             stuck = 1'b0;
  logic [CNT_W-1:0] stuck_val = '0;
  always @(posedge clk) begin
    if (start) cnt_q <= '0;
    else       cnt_q <= cnt_q + 8'd1;
  end
  assign count = stuck ? stuck_val : cnt_q;

  int starts = 0;
  always @(posedge clk) if (start) starts <= starts + 1;

  typedef struct packed {
    logic             to;
    logic [CNT_W-1:0] cnt;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command until accepted; optionally record the expected response.
  task automatic issue(input logic [CNT_W-1:0] t, input logic keep,
                       input logic eto, input logic [CNT_W-1:0] ec);
    int n = 0;
    host_if.cmd_valid  = 1'b1;
    host_if.cmd_target = t;
    while (!host_if.cmd_ready && n < 50) begin
      tick();
      n++;
    end
    check("cmd_accept_bound", 32'(n < 50), 32'd1);
    tick();
    host_if.cmd_valid = 1'b0;
    check("start_after_accept", 32'(start), 32'd1);
    if (keep) sb.push_back('{to: eto, cnt: ec});
  endtask

  // Cycles from the start-pulse cycle until rsp_valid is seen.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!host_if.rsp_valid && lat < 100) begin
      tick();
      lat++;
    end
    check("rsp_bound", 32'(lat < 100), 32'd1);
  endtask

  task automatic take_rsp(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_timeout"}, 32'(host_if.rsp_timeout), 32'(e.to));
      check({tag, "_count"},   32'(host_if.rsp_count),   32'(e.cnt));
    end
    host_if.rsp_ready = 1'b1;
    tick();
    host_if.rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int s0;
    logic seen;

    reset              = 1'b1;
    host_if.cmd_valid  = 1'b0;
    host_if.cmd_target = '0;
    host_if.rsp_ready  = 1'b0;
    tick(); tick(); tick();

    // Reset state
    check("rst_start",     32'(start), 32'd0);
    check("rst_rsp_valid", 32'(host_if.rsp_valid), 32'd0);
    check("rst_rsp_to",    32'(host_if.rsp_timeout), 32'd0);
    check("rst_rsp_count", 32'(host_if.rsp_count), 32'd0);
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(host_if.cmd_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("idle_cmd_ready", 32'(host_if.cmd_ready), 32'd1);

    // 1: target reached; hit at timer 5 -> response 7 cycles after start cycle
    s0 = starts;
    issue(8'd5, 1'b1, 1'b0, 8'd5);
    wait_rsp(lat);
    check("t1_latency", 32'(lat), 32'd7);
    check("t1_busy", 32'(busy), 32'd1);
    take_rsp("t1");
    check("t1_one_start", 32'(starts - s0), 32'd1);

    // 2: count stuck below target -> timeout after 16 WAIT cycles
    stuck = 1'b1; stuck_val = 8'd3;
    issue(8'd200, 1'b1, 1'b1, 8'd3);
    wait_rsp(lat);
    check("t2_latency", 32'(lat), 32'(TIMEOUT_CYC + 1));
    take_rsp("t2");
    stuck = 1'b0;

    // 3: response back-pressure, ignored second command, gap timing
    s0 = starts;
    issue(8'd5, 1'b1, 1'b0, 8'd5);
    wait_rsp(lat);
    host_if.cmd_valid  = 1'b1;
    host_if.cmd_target = 8'd9;
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_flags", {29'd0, host_if.rsp_valid, host_if.cmd_ready, busy}, 32'b101);
      check("t3_hold_data", {23'd0, host_if.rsp_timeout, host_if.rsp_count}, 32'd5);
      tick();
    end
    host_if.cmd_valid = 1'b0;
    take_rsp("t3");
    check("t3_gap1_ready", 32'(host_if.cmd_ready), 32'd0);
    tick();
    check("t3_gap2_ready", 32'(host_if.cmd_ready), 32'd0);
    tick();
    check("t3_idle_ready", 32'(host_if.cmd_ready), 32'd1);
    check("t3_one_start", 32'(starts - s0), 32'd1);

    // 4: target 0 -> hit on second WAIT cycle with count 1
    issue(8'd0, 1'b1, 1'b0, 8'd1);
    wait_rsp(lat);
    check("t4_latency", 32'(lat), 32'd3);
    take_rsp("t4");

    // 5: hit coincides with expiry -> hit wins
    issue(8'd15, 1'b1, 1'b0, 8'd15);
    wait_rsp(lat);
    check("t5_latency", 32'(lat), 32'(TIMEOUT_CYC + 1));
    take_rsp("t5");

    // 6a: reset during WAIT drops the run
    issue(8'd200, 1'b0, 1'b0, 8'd0);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    check("t6a_start", 32'(start), 32'd0);
    check("t6a_rsp_valid", 32'(host_if.rsp_valid), 32'd0);
    check("t6a_busy", 32'(busy), 32'd0);
    check("t6a_cmd_ready_in_rst", 32'(host_if.cmd_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("t6a_cmd_ready", 32'(host_if.cmd_ready), 32'd1);

    // 6b: reset while a response is pending drops it
    issue(8'd2, 1'b0, 1'b0, 8'd0);
    wait_rsp(lat);
    check("t6b_latency", 32'(lat), 32'd4);
    reset = 1'b1;
    tick();
    check("t6b_rsp_valid", 32'(host_if.rsp_valid), 32'd0);
    check("t6b_busy", 32'(busy), 32'd0);
    check("t6b_cmd_ready_in_rst", 32'(host_if.cmd_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("t6b_cmd_ready", 32'(host_if.cmd_ready), 32'd1);
    host_if.rsp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (host_if.rsp_valid) seen = 1'b1;
      tick();
    end
    host_if.rsp_ready = 1'b0;
    check("t6b_no_stale_rsp", 32'(seen), 32'd0);

    // Normal run after reset
    issue(8'd3, 1'b1, 1'b0, 8'd3);
    wait_rsp(lat);
    check("t7_latency", 32'(lat), 32'd5);
    take_rsp("t7");
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
